// File: rtl/mmc1_host_writer.sv
// CPU-side initiator for the MMC1 serial register-load protocol.
// Queued commands become five LSB-first D0 writes or a single D7=1 reset write.
module mmc1_host_writer #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_reset,
    input  logic [1:0] cmd_reg,
    input  logic [4:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] cmd_count,
    output logic       nROMSEL,
    output logic       CPU_RnW,
    output logic       CPU_D0,
    output logic       CPU_D7,
    output logic       CPU_A13,
    output logic       CPU_A14
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
    localparam logic [AW:0] FULL_FILL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        GAP
    } state_t;

    // entry layout: {reset, reg[1:0], data[4:0]}
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fill;
    logic          full, empty, push, pop;

    state_t      state, state_n;
    logic [7:0]  cur, cur_n;
    logic [2:0]  bit_idx, bit_n;
    logic [3:0]  gap_cnt, gap_n;
    logic        done_n;

    assign full      = (fill == FULL_FILL);
    assign empty     = (fill == '0);
    assign cmd_ready = ~full;
    assign push      = cmd_valid & ~full;
    assign busy      = (state != IDLE) | ~empty;

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_reset, cmd_reg, cmd_data};
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        cur_n   = cur;
        bit_n   = bit_idx;
        gap_n   = gap_cnt;
        done_n  = 1'b0;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    cur_n   = fifo_mem[rd_ptr];
                    bit_n   = '0;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                gap_n   = GAP_LOAD;
                state_n = GAP;
            end
            GAP: begin
                if (gap_cnt != '0) begin
                    gap_n = gap_cnt - 1'b1;
                end else if (!cur[7] && bit_idx != 3'd4) begin
                    bit_n   = bit_idx + 1'b1;
                    state_n = WRITE;
                end else begin
                    // completion can chain straight into the next queued command
                    done_n = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        cur_n   = fifo_mem[rd_ptr];
                        bit_n   = '0;
                        state_n = WRITE;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state     <= IDLE;
            cur       <= '0;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            done      <= 1'b0;
            cmd_count <= '0;
        end else begin
            state     <= state_n;
            cur       <= cur_n;
            bit_idx   <= bit_n;
            gap_cnt   <= gap_n;
            done      <= done_n;
            cmd_count <= cmd_count + {7'b0, done_n};
        end
    end

    // bus re-registered on the falling edge so it holds through the high phase
    always_ff @(negedge CLK or posedge RES) begin
        if (RES) begin
            nROMSEL <= 1'b1;
            CPU_RnW <= 1'b1;
            CPU_D0  <= 1'b0;
            CPU_D7  <= 1'b0;
            CPU_A13 <= 1'b0;
            CPU_A14 <= 1'b0;
        end else if (state == WRITE) begin
            nROMSEL <= 1'b0;
            CPU_RnW <= 1'b0;
            CPU_D0  <= cur[7] ? 1'b0 : cur[bit_idx];
            CPU_D7  <= cur[7];
            CPU_A13 <= cur[5];
            CPU_A14 <= cur[6];
        end else begin
            nROMSEL <= 1'b1;
            CPU_RnW <= 1'b1;
            CPU_D0  <= 1'b0;
            CPU_D7  <= 1'b0;
            CPU_A13 <= 1'b0;
            CPU_A14 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmc1_host_writer.sv
// Scoreboard bench for mmc1_host_writer: expected bus writes are queued at push time
// and a posedge monitor checks every write, done pulse and counter value.
module tb_mmc1_host_writer;

    localparam int unsigned GAP = 1;

    logic       CLK, RES;
    logic       cmd_valid, cmd_ready, cmd_reset;
    logic [1:0] cmd_reg;
    logic [4:0] cmd_data;
    logic       busy, done;
    logic [7:0] cmd_count;
    logic       nROMSEL, CPU_RnW, CPU_D0, CPU_D7, CPU_A13, CPU_A14;

    mmc1_host_writer #(.GAP_CYCLES(GAP), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RES(RES),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reset(cmd_reset),
        .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .busy(busy), .done(done), .cmd_count(cmd_count),
        .nROMSEL(nROMSEL), .CPU_RnW(CPU_RnW), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7),
        .CPU_A13(CPU_A13), .CPU_A14(CPU_A14)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // expected write word: {last, a14, a13, d7, d0}
    logic [4:0] sb[$];
    int   writes_seen = 0;
    int   dones_seen = 0;
    int   since_write = 0;
    logic prev_write = 1'b0;
    logic last_was_end = 1'b0;
    logic [7:0] exp_count = '0;
    logic saw_full = 1'b0;

    // behavioural MMC1 shift register fed by the observed bus writes
    logic [4:0] mmc_sr = '0;
    int         mmc_cnt = 0;
    logic [4:0] mmc_reg [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        logic [4:0] e;
        logic [1:0] a;
        forever begin
            @(posedge CLK);
            #1;
            if (RES) continue;
            if (!nROMSEL) begin
                check("adjacent_write", {31'b0, prev_write}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("write_word", {27'b0, CPU_A14, CPU_A13, CPU_D7, CPU_D0, CPU_RnW},
                          {27'b0, e[3:2], e[1], e[0], 1'b0});
                    last_was_end = e[4];
                end
                writes_seen++;
                since_write = 0;
                a = {CPU_A14, CPU_A13};
                if (CPU_D7) begin
                    mmc_sr = '0;
                    mmc_cnt = 0;
                end else begin
                    mmc_sr = {CPU_D0, mmc_sr[4:1]};
                    mmc_cnt++;
                    if (mmc_cnt == 5) begin
                        mmc_reg[a] = mmc_sr;
                        mmc_sr = '0;
                        mmc_cnt = 0;
                    end
                end
            end else begin
                if (since_write < 1000) since_write++;
            end
            prev_write = !nROMSEL;
            if (done) begin
                check("done_timing", {31'b0, last_was_end}, 32'd1);
                check("done_gap", since_write, GAP);
                exp_count = exp_count + 8'd1;
                check("cmd_count", {24'b0, cmd_count}, {24'b0, exp_count});
                dones_seen++;
                last_was_end = 1'b0;
            end
        end
    end

    task automatic push(input logic rst, input logic [1:0] rg, input logic [4:0] d);
        int n;
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_reset = rst;
        cmd_reg   = rg;
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 200) begin
            saw_full = 1'b1;
            @(negedge CLK);
            n++;
        end
        if (n >= 200) check("ready_timeout", 32'd1, 32'd0);
        if (rst) begin
            sb.push_back({1'b1, rg, 1'b1, 1'b0});
        end else begin
            for (int i = 0; i < 5; i++) sb.push_back({(i == 4), rg, 1'b0, d[i]});
        end
        @(posedge CLK);
    endtask

    task automatic release_valid();
        @(negedge CLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 3000) check("idle_timeout", 32'd1, 32'd0);
        @(negedge CLK);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RES = 1'b1;
        #1;
        check("rst_bus", {26'b0, nROMSEL, CPU_RnW, CPU_D0, CPU_D7, CPU_A13, CPU_A14},
              32'b110000);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_count", {24'b0, cmd_count}, 32'd0);
        check("rst_ready", {31'b0, cmd_ready}, 32'd1);
        sb.delete();
        exp_count = '0;
        last_was_end = 1'b0;
        prev_write = 1'b0;
        dones_seen = 0;
        @(negedge CLK);
        RES = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        RES = 1'b1;
        cmd_valid = 1'b0;
        cmd_reset = 1'b0;
        cmd_reg = '0;
        cmd_data = '0;
        for (int i = 0; i < 4; i++) mmc_reg[i] = '0;
        repeat (3) @(negedge CLK);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_ready", {31'b0, cmd_ready}, 32'd1);
        check("reset_count", {24'b0, cmd_count}, 32'd0);
        check("reset_bus", {26'b0, nROMSEL, CPU_RnW, CPU_D0, CPU_D7, CPU_A13, CPU_A14},
              32'b110000);
        RES = 1'b0;

        // single data load: D0 sequence 0,0,1,1,0 on $8000
        push(1'b0, 2'd0, 5'b01100);
        release_valid();
        wait_idle();
        check("t1_count", {24'b0, cmd_count}, 32'd1);
        check("t1_dones", dones_seen, 1);

        // shift-register reset write on $E000
        push(1'b1, 2'd3, 5'b10101);
        release_valid();
        wait_idle();
        check("t2_count", {24'b0, cmd_count}, 32'd2);

        // six back-to-back commands overflow the 4-deep queue
        saw_full = 1'b0;
        push(1'b0, 2'd1, 5'b10011);
        push(1'b0, 2'd2, 5'b01010);
        push(1'b1, 2'd0, 5'b00000);
        push(1'b0, 2'd3, 5'b11100);
        push(1'b0, 2'd0, 5'b00001);
        push(1'b0, 2'd1, 5'b11110);
        release_valid();
        check("t3_ready_dropped", {31'b0, saw_full}, 32'd1);
        wait_idle();
        check("t3_count", {24'b0, cmd_count}, 32'd8);

        // reset in the middle of a data load
        base = writes_seen;
        push(1'b0, 2'd1, 5'b10101);
        release_valid();
        n = 0;
        while (writes_seen < base + 2 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) check("t4_timeout", 32'd1, 32'd0);
        pulse_reset();
        base = writes_seen;
        push(1'b0, 2'd2, 5'b00011);
        release_valid();
        wait_idle();
        check("t4_writes", writes_seen - base, 5);
        check("t4_count", {24'b0, cmd_count}, 32'd1);

        // load an MMC1 model
        push(1'b1, 2'd0, 5'b00000);
        push(1'b0, 2'd0, 5'b11111);
        push(1'b0, 2'd3, 5'b00101);
        release_valid();
        wait_idle();
        check("t5_reg0", {27'b0, mmc_reg[0]}, 32'b11111);
        check("t5_reg3", {27'b0, mmc_reg[3]}, 32'b00101);
        check("t5_sr_cnt", mmc_cnt, 0);

        // counter wrap after 256 completions
        pulse_reset();
        for (int i = 0; i < 256; i++) push(1'b1, 2'(i), 5'b00000);
        release_valid();
        wait_idle();
        check("t6_count_wrap", {24'b0, cmd_count}, 32'd0);
        check("t6_dones", dones_seen, 256);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
